// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared mode encodings and access helpers for the data memory arbiter
package dmem_pkg;

    typedef enum logic [2:0] {
        MODE_BYTE  = 3'b000,
        MODE_HALF  = 3'b001,
        MODE_WORD  = 3'b010,
        MODE_UBYTE = 3'b011,
        MODE_UHALF = 3'b100
    } mem_mode_e;

    typedef enum logic {
        OWNER_LSU = 1'b0,
        OWNER_DMA = 1'b1
    } owner_e;

    // Illegal codes report size 1 so the range check stays well defined.
    function automatic logic [2:0] size_of(input logic [2:0] mode);
        case (mode)
            MODE_HALF, MODE_UHALF: size_of = 3'd2;
            MODE_WORD:             size_of = 3'd4;
            default:               size_of = 3'd1;
        endcase
    endfunction

    // Unsigned modes only make sense for loads.
    function automatic logic is_legal(input logic [2:0] mode, input logic we);
        case (mode)
            MODE_BYTE, MODE_HALF, MODE_WORD: is_legal = 1'b1;
            MODE_UBYTE, MODE_UHALF:          is_legal = !we;
            default:                         is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - one requester's request/response channel into the arbiter
interface dmem_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  mode;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, we, addr, wdata, mode,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, we, addr, wdata, mode,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_arbiter_check.sv
// rtl/dmem_arbiter_check.sv - combinational legality, alignment and range check of one access
module dmem_access_check
    import dmem_pkg::*;
#(
    parameter int unsigned DMEM_BYTES = 100
) (
    input  logic [31:0] i_addr,
    input  logic [2:0]  i_mode,
    input  logic        i_we,
    output logic        o_err
);

    logic [32:0] w_last;
    logic        w_align_err;
    logic        w_range_err;

    // 33-bit sum so an address near 2^32 cannot wrap back into range.
    assign w_last      = {1'b0, i_addr} + {30'd0, size_of(i_mode)} - 33'd1;
    assign w_range_err = (w_last >= 33'(DMEM_BYTES));

    always_comb begin
        w_align_err = 1'b0;
        case (i_mode)
            MODE_HALF, MODE_UHALF: w_align_err = i_addr[0];
            MODE_WORD:             w_align_err = |i_addr[1:0];
            default:               w_align_err = 1'b0;
        endcase
    end

    assign o_err = !is_legal(i_mode, i_we) || w_align_err || w_range_err;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - LSU-priority arbiter for the shared data memory with DMA starvation guard
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DMEM_BYTES = 100,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_req_if.slave   lsu,
    dmem_req_if.slave   dma,
    output logic        o_mem_wr_en,
    output logic        o_mem_rd_en,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [2:0]  o_mem_mode,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    logic [3:0]  r_starve_cnt;
    logic        r_rsp_valid;
    owner_e      r_rsp_owner;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic        w_lsu_gnt;
    logic        w_dma_gnt;
    logic        w_accept;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [2:0]  w_mode;
    logic        w_chk_err;
    logic        w_lsu_rsp;
    logic        w_dma_rsp;

    // Gating with rst_n keeps every combinational output at 0 while reset is held.
    always_comb begin
        w_dma_gnt = rst_n && dma.req_valid && (!lsu.req_valid || (r_starve_cnt == LP_MAX_WAIT));
        w_lsu_gnt = rst_n && lsu.req_valid && !w_dma_gnt;
        w_accept  = w_lsu_gnt || w_dma_gnt;
        w_we      = 1'b0;
        w_addr    = '0;
        w_wdata   = '0;
        w_mode    = '0;
        if (w_lsu_gnt) begin
            w_we    = lsu.we;
            w_addr  = lsu.addr;
            w_wdata = lsu.wdata;
            w_mode  = lsu.mode;
        end else if (w_dma_gnt) begin
            w_we    = dma.we;
            w_addr  = dma.addr;
            w_wdata = dma.wdata;
            w_mode  = dma.mode;
        end
    end

    dmem_access_check #(
        .DMEM_BYTES(DMEM_BYTES)
    ) u_check (
        .i_addr (w_addr),
        .i_mode (w_mode),
        .i_we   (w_we),
        .o_err  (w_chk_err)
    );

    assign lsu.req_ready = w_lsu_gnt;
    assign dma.req_ready = w_dma_gnt;
    assign o_mem_addr    = w_addr;
    assign o_mem_wdata   = w_wdata;
    assign o_mem_mode    = w_mode;
    assign o_mem_wr_en   = w_accept && w_we && !w_chk_err;
    assign o_mem_rd_en   = w_accept && !w_we && !w_chk_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_owner  <= OWNER_LSU;
            r_rsp_err    <= 1'b0;
            r_rsp_rdata  <= '0;
        end else begin
            if (!dma.req_valid || w_dma_gnt) begin
                r_starve_cnt <= '0;
            end else if (w_lsu_gnt && (r_starve_cnt != LP_MAX_WAIT)) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_rsp_owner <= w_dma_gnt ? OWNER_DMA : OWNER_LSU;
                r_rsp_err   <= w_chk_err;
                r_rsp_rdata <= o_mem_rd_en ? i_mem_rdata : 32'd0;
            end
        end
    end

    assign w_lsu_rsp     = r_rsp_valid && (r_rsp_owner == OWNER_LSU);
    assign w_dma_rsp     = r_rsp_valid && (r_rsp_owner == OWNER_DMA);
    assign lsu.rsp_valid = w_lsu_rsp;
    assign lsu.rsp_rdata = w_lsu_rsp ? r_rsp_rdata : 32'd0;
    assign lsu.rsp_err   = w_lsu_rsp && r_rsp_err;
    assign dma.rsp_valid = w_dma_rsp;
    assign dma.rsp_rdata = w_dma_rsp ? r_rsp_rdata : 32'd0;
    assign dma.rsp_err   = w_dma_rsp && r_rsp_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a little-endian memory model
module tb_dmem_arbiter;

    typedef struct {
        logic        dma;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_wr_en, mem_rd_en;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_mode;
    logic [7:0]  mem [0:99];
    logic [6:0]  a0, a1, a2, a3;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sb[$];

    dmem_req_if lsu_if ();
    dmem_req_if dma_if ();

    dmem_arbiter #(.DMEM_BYTES(100), .MAX_WAIT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lsu         (lsu_if),
        .dma         (dma_if),
        .o_mem_wr_en (mem_wr_en),
        .o_mem_rd_en (mem_rd_en),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_mode  (mem_mode),
        .i_mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign a0 = mem_addr[6:0];
    assign a1 = a0 + 7'd1;
    assign a2 = a0 + 7'd2;
    assign a3 = a0 + 7'd3;

    always_comb begin
        mem_rdata = '0;
        if (mem_rd_en) begin
            case (mem_mode)
                3'b000:  mem_rdata = {{24{mem[a0][7]}}, mem[a0]};
                3'b001:  mem_rdata = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
                3'b010:  mem_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
                3'b011:  mem_rdata = {24'd0, mem[a0]};
                3'b100:  mem_rdata = {16'd0, mem[a1], mem[a0]};
                default: mem_rdata = '0;
            endcase
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 100; i++) mem[i] <= 8'd0;
        end else if (mem_wr_en) begin
            mem[a0] <= mem_wdata[7:0];
            if (mem_mode != 3'b000) mem[a1] <= mem_wdata[15:8];
            if (mem_mode == 3'b010) begin
                mem[a2] <= mem_wdata[23:16];
                mem[a3] <= mem_wdata[31:24];
            end
        end
    end

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_lsu(input logic v, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] mode);
        lsu_if.req_valid = v;
        lsu_if.we        = we;
        lsu_if.addr      = addr;
        lsu_if.wdata     = wdata;
        lsu_if.mode      = mode;
    endtask

    task automatic set_dma(input logic v, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] mode);
        dma_if.req_valid = v;
        dma_if.we        = we;
        dma_if.addr      = addr;
        dma_if.wdata     = wdata;
        dma_if.mode      = mode;
    endtask

    // gnt: 0 none, 1 LSU, 2 DMA. Called #1 after a rising edge with inputs already set.
    task automatic step(input int gnt, input logic wr, input logic rd,
                        input logic [31:0] rdata, input logic err);
        logic [1:0] exp_rdy;
        exp_t e;
        @(negedge clk);
        exp_rdy = (gnt == 1) ? 2'b10 : (gnt == 2) ? 2'b01 : 2'b00;
        chk("ready", {66'd0, lsu_if.req_ready, dma_if.req_ready}, {66'd0, exp_rdy});
        chk("mem_en", {66'd0, mem_wr_en, mem_rd_en}, {66'd0, wr, rd});
        if (gnt != 0) begin
            e.dma = (gnt == 2); e.rdata = rdata; e.err = err; e.cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [67:0] outs_all();
        return {20'd0, lsu_if.req_ready, dma_if.req_ready, lsu_if.rsp_valid, dma_if.rsp_valid,
                lsu_if.rsp_err, dma_if.rsp_err, mem_wr_en, mem_rd_en, mem_mode,
                mem_addr | mem_wdata | lsu_if.rsp_rdata | dma_if.rsp_rdata, 7'd0};
    endfunction

    initial begin : monitor
        exp_t e;
        logic [67:0] act, expv;
        forever begin
            @(negedge clk);
            act = {1'b0, lsu_if.rsp_valid, lsu_if.rsp_rdata, lsu_if.rsp_err,
                   dma_if.rsp_valid, dma_if.rsp_rdata, dma_if.rsp_err};
            if (lsu_if.rsp_valid || dma_if.rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", act, 68'd0);
                end else begin
                    e = sb.pop_front();
                    expv = e.dma ? {1'b0, 1'b0, 32'd0, 1'b0, 1'b1, e.rdata, e.err}
                                 : {1'b0, 1'b1, e.rdata, e.err, 1'b0, 32'd0, 1'b0};
                    chk("rsp", act, expv);
                end
            end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                total++;
                bad++;
                $display("FAIL missing_rsp act=none exp_dma=%0d rdata=%h t=%0t", e.dma, e.rdata, $time);
            end
        end
    end

    initial begin : stim
        set_lsu(1'b1, 1'b0, 32'd8, 32'd0, 3'b010);
        set_dma(1'b1, 1'b0, 32'd0, 32'd0, 3'b010);
        #12;
        chk("reset_outs", outs_all(), 68'd0);
        @(posedge clk);
        #1;
        set_dma(1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        set_lsu(1'b1, 1'b1, 32'd8, 32'hDEADBEEF, 3'b010);
        rst_n = 1'b1;
        step(1, 1'b1, 1'b0, 32'd0, 1'b0);
        set_lsu(1'b1, 1'b0, 32'd8, 32'd0, 3'b010);
        step(1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        set_lsu(1'b0, 1'b1, 32'd44, 32'h12345678, 3'b010);
        @(negedge clk);
        chk("idle_bus", {35'd0, mem_addr, mem_mode}, 68'd0);
        step(0, 1'b0, 1'b0, 32'd0, 1'b0);

        set_lsu(1'b1, 1'b0, 32'd3, 32'd0, 3'b001);
        step(1, 1'b0, 1'b0, 32'd0, 1'b1);
        set_lsu(1'b1, 1'b1, 32'd97, 32'h11223344, 3'b010);
        step(1, 1'b0, 1'b0, 32'd0, 1'b1);
        set_lsu(1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        set_dma(1'b1, 1'b1, 32'd0, 32'h55, 3'b011);
        step(2, 1'b0, 1'b0, 32'd0, 1'b1);
        set_dma(1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        set_lsu(1'b1, 1'b0, 32'd0, 32'd0, 3'b101);
        step(1, 1'b0, 1'b0, 32'd0, 1'b1);
        set_lsu(1'b1, 1'b0, 32'd96, 32'd0, 3'b010);
        step(1, 1'b0, 1'b1, 32'd0, 1'b0);
        set_lsu(1'b1, 1'b0, 32'd0, 32'd0, 3'b011);
        step(1, 1'b0, 1'b1, 32'd0, 1'b0);
        set_lsu(1'b1, 1'b0, 32'hFFFFFFFE, 32'd0, 3'b000);
        step(1, 1'b0, 1'b0, 32'd0, 1'b1);

        set_lsu(1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        set_dma(1'b1, 1'b1, 32'd99, 32'h80, 3'b000);
        step(2, 1'b1, 1'b0, 32'd0, 1'b0);
        set_dma(1'b1, 1'b0, 32'd99, 32'd0, 3'b000);
        step(2, 1'b0, 1'b1, 32'hFFFFFF80, 1'b0);
        set_dma(1'b1, 1'b0, 32'd99, 32'd0, 3'b011);
        step(2, 1'b0, 1'b1, 32'h00000080, 1'b0);
        set_dma(1'b1, 1'b0, 32'd98, 32'd0, 3'b001);
        step(2, 1'b0, 1'b1, 32'hFFFF8000, 1'b0);
        set_dma(1'b1, 1'b0, 32'd99, 32'd0, 3'b100);
        step(2, 1'b0, 1'b0, 32'd0, 1'b1);

        set_dma(1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        set_lsu(1'b1, 1'b0, 32'd8, 32'd0, 3'b010);
        step(1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        set_lsu(1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        set_dma(1'b1, 1'b0, 32'd99, 32'd0, 3'b011);
        step(2, 1'b0, 1'b1, 32'h00000080, 1'b0);
        set_dma(1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        set_lsu(1'b1, 1'b0, 32'd8, 32'd0, 3'b000);
        step(1, 1'b0, 1'b1, 32'hFFFFFFEF, 1'b0);
        set_lsu(1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        set_dma(1'b1, 1'b0, 32'd10, 32'd0, 3'b100);
        step(2, 1'b0, 1'b1, 32'h0000DEAD, 1'b0);

        set_lsu(1'b1, 1'b0, 32'd8, 32'd0, 3'b010);
        set_dma(1'b1, 1'b0, 32'd96, 32'd0, 3'b010);
        for (int i = 0; i < 11; i++) begin
            if (i == 4 || i == 9) step(2, 1'b0, 1'b1, 32'h80000000, 1'b0);
            else                  step(1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        end

        step(1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        step(1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        chk("pre_reset_ready", {66'd0, lsu_if.req_ready, dma_if.req_ready}, {66'd0, 2'b10});
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset_async_outs", outs_all(), 68'd0);
        repeat (2) begin
            @(negedge clk);
            chk("reset_hold_outs", outs_all(), 68'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) step(2, 1'b0, 1'b1, 32'd0, 1'b0);
            else        step(1, 1'b0, 1'b1, 32'd0, 1'b0);
        end
        set_lsu(1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        set_dma(1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 68'(sb.size()), 68'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
